seq_div_ctrl: RTL

- Sequential controller for unsigned restoring division.
- Time-shares one adder_subtractor instance, WIDTH+1 bits wide, fixed in subtract mode (Op=1, Cin=0).
- Uses the sign bit of the trial difference, the same rule as the decision module, to pick the quotient bit.
- Sits between a requester issuing start/operands and downstream logic consuming quotient/remainder on a done pulse.

---
 rtl/seq_div_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/seq_div_ctrl.sv
// seq_div_ctrl: sequential unsigned restoring divider controller.
// A single (WIDTH+1)-bit adder_subtractor, fixed in subtract mode, forms the
// trial difference A - M. Its sign bit selects the quotient bit and decides
// whether A takes the difference or keeps its old value (implicit restore).
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only in IDLE
//   dividend     unsigned dividend, captured with an accepted start
//   divisor      unsigned divisor, captured with an accepted start
//   quotient     registered quotient (all ones on divide-by-zero)
//   remainder    registered remainder (dividend on divide-by-zero)
//   busy         high from the accepting edge until the return to IDLE
//   done         one-cycle pulse, results valid
//   div_by_zero  registered flag for the last operation
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | shift {A,Q} left by one, Q[0] cleared
// SUB   | trial subtract, set quotient bit, count down
// DONE  | results valid, done pulse

// Generic adder/subtractor: op=1 inverts b and adds one, so with cin=0 the
// result is a - b.
module adder_subtractor #(
  parameter int N = 9
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_op,
  input  logic         i_cin,
  output logic [N-1:0] o_sum
);
  assign o_sum = i_a + (i_b ^ {N{i_op}}) + N'(i_op ^ i_cin);
endmodule

module seq_div_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_SUB, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic [WIDTH:0]   w_trial;
  logic             w_take;
  logic [WIDTH:0]   w_a_new;
  logic [WIDTH-1:0] w_q_new;
  logic             w_zero;
  logic             w_last;

  adder_subtractor #(.N(WIDTH + 1)) u_addsub (
    .i_a   (r_a),
    .i_b   ({1'b0, r_m}),
    .i_op  (1'b1),
    .i_cin (1'b0),
    .o_sum (w_trial)
  );

  // Non-negative trial difference means the divisor fits.
  assign w_take  = ~w_trial[WIDTH];
  assign w_a_new = w_take ? w_trial : r_a;
  assign w_q_new = {r_q[WIDTH-1:1], w_take};
  assign w_zero  = (divisor == '0);
  assign w_last  = (r_count == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_zero ? S_DONE : S_SHIFT;
      S_SHIFT: w_next = S_SUB;
      S_SUB:   w_next = w_last ? S_DONE : S_SHIFT;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_count <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_zero) begin
              r_quot <= '1;
              r_rem  <= dividend;
              r_dbz  <= 1'b1;
            end else begin
              r_a     <= '0;
              r_q     <= dividend;
              r_m     <= divisor;
              r_count <= CW'(WIDTH);
              r_dbz   <= 1'b0;
            end
          end
        end
        S_SHIFT: begin
          // A[WIDTH] is always 0 here because A < M after every SUB.
          r_a <= {r_a[WIDTH-1:0], r_q[WIDTH-1]};
          r_q <= {r_q[WIDTH-2:0], 1'b0};
        end
        S_SUB: begin
          r_a     <= w_a_new;
          r_q     <= w_q_new;
          r_count <= r_count - CW'(1);
          if (w_last) begin
            r_quot <= w_q_new;
            r_rem  <= w_a_new[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule
